// File: rtl/noc_injection_arbiter.sv
// noc_injection_arbiter: packet-granular round-robin sharing of one router injection port with
// credit flow control. Define NOC_INJ_STATS_EN to add the pkt_count/stall_count outputs.
module noc_injection_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2,
  localparam int PTR_W            = $clog2(NUM_REQ),
  localparam int CRED_W           = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [FLIT_WIDTH-1:0] req_data [NUM_REQ],
  input  logic [DEST_WIDTH-1:0] req_dest [NUM_REQ],
  input  logic [NUM_REQ-1:0]    req_is_tail,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  credit_err,
`ifdef NOC_INJ_STATS_EN
  output logic [31:0]           pkt_count,
  output logic [31:0]           stall_count,
`endif
  output logic                  dbg_state,
  output logic [PTR_W-1:0]      dbg_rr_ptr,
  output logic [PTR_W-1:0]      dbg_grant,
  output logic [CRED_W-1:0]     dbg_credits
);

  // Handshake: a flit moves when req_valid[i] && req_ready[i] in the same cycle. Ready never
  // depends on this cycle's credit_in, and dropping valid mid-packet keeps ownership (stall).

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant;
  logic [CRED_W-1:0] credits;

  logic              can_send;
  logic              found;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  sel;
  logic              sel_tail;
  logic              accept;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  assign can_send = (credits != '0);

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) cand = cand - (PTR_W + 1)'(NUM_REQ);
      if (!found && req_valid[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  assign sel      = (state == LOCKED) ? grant : winner;
  assign sel_tail = req_is_tail[sel];

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == LOCKED || found)) req_ready[sel] = can_send;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          grant <= winner;
          if (sel_tail) rr_ptr <= next_ptr(winner);
          else          state  <= LOCKED;
        end
        LOCKED: begin
          if (sel_tail) begin
            state  <= IDLE;
            rr_ptr <= next_ptr(grant);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= CRED_W'(FLIT_BUFFER_DEPTH);
      credit_err <= 1'b0;
    end else if (accept && !credit_in) begin
      credits <= credits - 1'b1;
    end else if (!accept && credit_in) begin
      if (credits == CRED_W'(FLIT_BUFFER_DEPTH)) credit_err <= 1'b1;
      else                                      credits    <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= accept;
      if (accept) begin
        data_out    <= req_data[sel];
        dest_out    <= req_dest[sel];
        is_tail_out <= sel_tail;
      end
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (accept && sel_tail)        pkt_count   <= pkt_count + 32'd1;
      if (|req_valid && !can_send)   stall_count <= stall_count + 32'd1;
    end
  end
`endif

  assign dbg_state   = (state == LOCKED);
  assign dbg_rr_ptr  = rr_ptr;
  assign dbg_grant   = grant;
  assign dbg_credits = credits;

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Bench for noc_injection_arbiter: directed vector table, hand sequences for reset and
// round-robin order, then random traffic against a cycle-level reference model.
module tb_noc_injection_arbiter;
  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int FW  = 256;
  localparam int D   = 2;
  localparam int SBW = FW + DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [FW-1:0] req_data [N];
  logic [DW-1:0] req_dest [N];
  logic [N-1:0]  req_is_tail = '0;
  logic [N-1:0]  req_ready;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in = 1'b0;
  logic          credit_err;
`ifdef NOC_INJ_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   stall_count;
`endif
  logic          dbg_state;
  logic [1:0]    dbg_rr_ptr;
  logic [1:0]    dbg_grant;
  logic [1:0]    dbg_credits;

  noc_injection_arbiter #(.NUM_REQ(N), .DEST_WIDTH(DW), .FLIT_WIDTH(FW), .FLIT_BUFFER_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_dest(req_dest),
    .req_is_tail(req_is_tail), .req_ready(req_ready), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in), .credit_err(credit_err),
`ifdef NOC_INJ_STATS_EN
    .pkt_count(pkt_count), .stall_count(stall_count),
`endif
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_grant(dbg_grant), .dbg_credits(dbg_credits)
  );

  // Clock
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Scoreboard and reference model state
  logic [SBW-1:0] exp_q[$];
  int m_credits, m_owner, m_rr, m_err, m_pkts, m_stalls;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] tail;
    logic       credit_in;
    logic [3:0] exp_ready;
    logic       exp_send;
    logic [1:0] exp_credits;
    logic       exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [SBW-1:0] act, input logic [SBW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Drivers
  task automatic drive(input logic [3:0] v, input logic [3:0] t, input logic ci);
    req_valid   = v;
    req_is_tail = t;
    credit_in   = ci;
    for (int i = 0; i < N; i++) begin
      for (int w = 0; w < FW / 32; w++) req_data[i][w*32 +: 32] = $urandom();
      req_dest[i] = DW'($urandom_range(0, 15));
    end
  endtask

  task automatic model_reset();
    m_credits = D; m_owner = -1; m_rr = 0; m_err = 0; m_pkts = 0; m_stalls = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},   SBW'(req_ready), SBW'(0));
    check({tag, "_send"},    SBW'(send_out), SBW'(0));
    check({tag, "_data"},    SBW'(data_out), SBW'(0));
    check({tag, "_dest"},    SBW'(dest_out), SBW'(0));
    check({tag, "_tail"},    SBW'(is_tail_out), SBW'(0));
    check({tag, "_err"},     SBW'(credit_err), SBW'(0));
    check({tag, "_credits"}, SBW'(dbg_credits), SBW'(D));
    check({tag, "_rr"},      SBW'(dbg_rr_ptr), SBW'(0));
    check({tag, "_state"},   SBW'(dbg_state), SBW'(0));
    check({tag, "_grant"},   SBW'(dbg_grant), SBW'(0));
`ifdef NOC_INJ_STATS_EN
    check({tag, "_pkts"},    SBW'(pkt_count), SBW'(0));
    check({tag, "_stalls"},  SBW'(stall_count), SBW'(0));
`endif
  endtask

  // One random cycle checked against the reference model (entered and left at negedge).
  task automatic rand_step();
    logic [3:0] v, t, er;
    logic       ci, hit;
    int         acc, idx;
    v  = 4'($urandom_range(0, 15));
    t  = 4'($urandom_range(0, 15));
    ci = ($urandom_range(0, 9) < 4);
    drive(v, t, ci);
    er  = '0;
    acc = -1;
    hit = 1'b0;
    if (m_owner >= 0) begin
      if (m_credits != 0) er[m_owner] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!hit && v[idx]) begin
          hit = 1'b1;
          if (m_credits != 0) er[idx] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) if (er[i] && v[i]) acc = i;
    if (acc >= 0) exp_q.push_back({t[acc], req_dest[acc], req_data[acc]});
    #1 check("rnd_ready", SBW'(req_ready), SBW'(er));
    if (v != 0 && m_credits == 0) m_stalls++;
    if (acc >= 0 && !ci) m_credits--;
    else if (acc < 0 && ci) begin
      if (m_credits == D) m_err = 1;
      else m_credits++;
    end
    if (acc >= 0) begin
      if (t[acc]) begin
        m_owner = -1;
        m_rr    = (acc + 1) % N;
        m_pkts++;
      end else begin
        m_owner = acc;
      end
    end
    @(negedge clk);
    check("rnd_send", SBW'(send_out), SBW'(acc >= 0));
    if (send_out && exp_q.size() > 0)
      check("rnd_flit", {is_tail_out, dest_out, data_out}, exp_q.pop_front());
    check("rnd_credits", SBW'(dbg_credits), SBW'(m_credits));
    check("rnd_err", SBW'(credit_err), SBW'(m_err));
  endtask

  initial begin
    int order [5];
    logic [DW-1:0] exp_dest;
    order = '{0, 1, 2, 3, 0};

    vecs[0]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
    vecs[4]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
    vecs[9]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b1};
    vecs[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[11] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};
    vecs[12] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1};
    vecs[14] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[15] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[16] = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[17] = '{4'b0100, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1};
    vecs[18] = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[19] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1};

    // Reset with every source requesting: nothing may be granted.
    drive(4'b1111, 4'b1111, 1'b1);
    #1 rst_n = 1'b0;
    #2 check_reset_state("rst");
    @(negedge clk);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Directed table: credit exhaustion, saturation, round robin, packet lock.
    for (int n = 0; n < NV; n++) begin
      drive(vecs[n].valid, vecs[n].tail, vecs[n].credit_in);
      #1 check($sformatf("tbl%0d_ready", n), SBW'(req_ready), SBW'(vecs[n].exp_ready));
      @(negedge clk);
      check($sformatf("tbl%0d_send", n), SBW'(send_out), SBW'(vecs[n].exp_send));
      check($sformatf("tbl%0d_credits", n), SBW'(dbg_credits), SBW'(vecs[n].exp_credits));
      check($sformatf("tbl%0d_err", n), SBW'(credit_err), SBW'(vecs[n].exp_err));
    end

    // Reset in the middle of a multi-flit packet from req3.
    for (int n = 0; n < 2; n++) begin
      drive(4'b1000, 4'b0000, 1'b1);
      req_data[3] = '1;
      req_dest[3] = 4'hf;
      @(negedge clk);
    end
    check("mid_state", SBW'(dbg_state), SBW'(1));
    check("mid_grant", SBW'(dbg_grant), SBW'(3));
    check("mid_send", SBW'(send_out), SBW'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // All four single-flit sources: grants rotate 0,1,2,3,0 with no gap.
    for (int n = 0; n < 5; n++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      exp_dest = req_dest[order[n]];
      #1 check($sformatf("rr%0d_ready", n), SBW'(req_ready), SBW'(4'b0001 << order[n]));
      @(negedge clk);
      check($sformatf("rr%0d_send", n), SBW'(send_out), SBW'(1));
      check($sformatf("rr%0d_dest", n), SBW'(dest_out), SBW'(exp_dest));
    end

    // Random traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 1500; n++) rand_step();
`ifdef NOC_INJ_STATS_EN
    check("stat_pkts", SBW'(pkt_count), SBW'(m_pkts));
    check("stat_stalls", SBW'(stall_count), SBW'(m_stalls));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
